// File: rtl/serial_595_tx_pkg.sv
// serial_595_tx_pkg
//   Shared types for the 74HC595-style serial transmitter.
//   Holds the FSM state encoding constants and the state enum built on them.
package serial_595_tx_pkg;

  localparam logic [1:0] ST_IDLE_ENC     = 2'b00;
  localparam logic [1:0] ST_SHIFT_LO_ENC = 2'b01;
  localparam logic [1:0] ST_SHIFT_HI_ENC = 2'b10;
  localparam logic [1:0] ST_LATCH_ENC    = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE_ENC,
    SHIFT_LO = ST_SHIFT_LO_ENC,
    SHIFT_HI = ST_SHIFT_HI_ENC,
    LATCH    = ST_LATCH_ENC
  } tx_state_e;

endpackage

// File: rtl/serial_tick_gen.sv
// serial_tick_gen
//   Half-period tick generator. Counts modulo div and pulses tick_o on the
//   last clk cycle of each phase. Holding restart_i high keeps the counter at
//   zero so the first phase after leaving IDLE is a full div cycles long; every
//   other phase boundary coincides with a tick, so the counter wraps to zero
//   exactly on state entry.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   restart_i  hold counter at zero (asserted while the FSM is idle)
//   tick_o     high on the final cycle of a div-cycle phase
module serial_tick_gen #(
  parameter int div = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = $clog2(div + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == CW'(div - 1)) && !restart_i;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_595_tx.sv
// serial_595_tx
//   Serialises a parallel word into a 74HC595-style shift register: data on
//   ser_data, shift clock on ser_clk, storage latch strobe on ser_latch.
//   Each bit takes div cycles with ser_clk low, then div cycles with ser_clk
//   high; after the last bit ser_latch is pulsed for div cycles.
//   Handshake: a word is taken on a rising clk edge where valid_in and
//   ready_out are both high; ready_out is high only in IDLE, and nothing is
//   queued while a word is in flight.
//   Bit order is MSB first; define SERIAL_595_TX_LSB_FIRST_EN for LSB first.
//   All outputs come straight from flops loaded with next-state values.
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   data_in     parallel word to send
//   valid_in    data_in is valid
//   ready_out   transmitter can accept a word
//   ser_clk     serial shift clock
//   ser_data    serial data bit
//   ser_latch   storage-register latch strobe
//   busy        FSM not in IDLE
//   state_o     current FSM state (debug observation)
module serial_595_tx
  import serial_595_tx_pkg::*;
#(
  parameter int w_data = 8,
  parameter int div    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [w_data-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic              ser_clk,
  output logic              ser_data,
  output logic              ser_latch,
  output logic              busy,
  output tx_state_e         state_o
);

  localparam int BCW = $clog2(w_data + 1);

  tx_state_e         state_q, state_d;
  logic [w_data-1:0] shift_q, shift_d;
  logic [w_data-1:0] shifted;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic              tick;
  logic              restart;
  logic              next_bit;

  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic ser_clk_q, ser_clk_d;
  logic ser_data_q, ser_data_d;
  logic ser_latch_q, ser_latch_d;

  assign restart = (state_q == IDLE);

  serial_tick_gen #(.div(div)) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // The bit on the wire is always at one end of the shift register; the
  // register moves one place when a bit's high phase ends.
`ifdef SERIAL_595_TX_LSB_FIRST_EN
  assign shifted  = {1'b0, shift_q[w_data-1:1]};
  assign next_bit = shift_d[0];
`else
  assign shifted  = {shift_q[w_data-2:0], 1'b0};
  assign next_bit = shift_d[w_data-1];
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      IDLE: begin
        if (valid_in && ready_q) begin
          shift_d   = data_in;
          bit_cnt_d = '0;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (tick) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick) begin
          bit_cnt_d = bit_cnt_q + BCW'(1);
          shift_d   = shifted;
          state_d   = (bit_cnt_q == BCW'(w_data - 1)) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output flops are loaded from the next state so they line up with state_q.
  // ser_data only takes a new value on entry to SHIFT_LO; it holds through
  // SHIFT_HI and LATCH and is cleared in IDLE.
  always_comb begin
    ready_d     = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    ser_clk_d   = (state_d == SHIFT_HI);
    ser_latch_d = (state_d == LATCH);
    ser_data_d  = 1'b0;
    case (state_d)
      SHIFT_LO, SHIFT_HI: ser_data_d = next_bit;
      LATCH:              ser_data_d = ser_data_q;
      default:            ser_data_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      ser_clk_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_latch_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      ser_clk_q   <= ser_clk_d;
      ser_data_q  <= ser_data_d;
      ser_latch_q <= ser_latch_d;
    end
  end

  assign ready_out = ready_q;
  assign busy      = busy_q;
  assign ser_clk   = ser_clk_q;
  assign ser_data  = ser_data_q;
  assign ser_latch = ser_latch_q;
  assign state_o   = state_q;

endmodule
